// File: rtl/icache_nway_if.sv
// icache_nway_if: fetch, CACHE-instruction and read-bridge signals.
// slave = cache side, master = fetch stage / AXI bridge side.
interface icache_nway_if #(
    parameter int LINE_W = 256,
    parameter int RN_W   = 4
);
    logic              valid;
    logic              uncache;
    logic [31:0]       addr;
    logic              addr_ok;
    logic              data_ok;
    logic [LINE_W-1:0] rdata;
    logic [RN_W-1:0]   rnum;
    logic              cache_inst_valid;
    logic [2:0]        cache_inst_op;
    logic [31:0]       cache_inst_addr;
    logic              cache_inst_ok;
    logic              rd_req;
    logic              rd_type;
    logic [31:0]       rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic [LINE_W-1:0] ret_data;

    modport slave (
        input  valid, uncache, addr,
        input  cache_inst_valid, cache_inst_op, cache_inst_addr,
        input  rd_rdy, ret_valid, ret_data,
        output addr_ok, data_ok, rdata, rnum, cache_inst_ok,
        output rd_req, rd_type, rd_addr
    );

    modport master (
        output valid, uncache, addr,
        output cache_inst_valid, cache_inst_op, cache_inst_addr,
        output rd_rdy, ret_valid, ret_data,
        input  addr_ok, data_ok, rdata, rnum, cache_inst_ok,
        input  rd_req, rd_type, rd_addr
    );
endinterface

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative blocking read-only icache.
// Define ICACHE_PERF_CNT_EN to add perf_hit/perf_miss counters.
module icache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_BYTES = 32
) (
    input  logic        clk,
    input  logic        resetn,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss,
`endif
    icache_nway_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WPL    = LINE_BYTES / 4;
    localparam int WO_W   = OFF_W - 2;
    localparam int RN_W   = WO_W + 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS, REFILL, UREQ, URESP, CLOOK, CCLR
    } state_t;

    state_t state, state_n;

    logic [TAG_W-1:0]  tag_ram  [WAYS][SETS];
    logic [LINE_W-1:0] data_ram [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q    [WAYS];
    logic [LINE_W-1:0] data_q   [WAYS];
    logic [WAYS-1:0]   vld      [SETS];
    logic [WAY_W-1:0]  rr       [SETS];

    logic [TAG_W-1:0]  b_tag;
    logic [IDX_W-1:0]  b_idx;
    logic [OFF_W-1:0]  b_off;
    logic [IDX_W-1:0]  c_idx;
    logic [WAYS-1:0]   clr_mask, clr_mask_n;
    logic [WAY_W-1:0]  victim, victim_n;

    logic [IDX_W-1:0]  a_idx, ci_idx, rd_idx;
    logic [TAG_W-1:0]  ci_tag;
    logic              ok_c, acc, ci_start, rd_en;
    logic [WAYS-1:0]   hit_vec, ci_vec;
    logic              hit, found;
    logic [LINE_W-1:0] hit_line, line_src, rdata_sh;
    logic [RN_W-1:0]   rnum_full;
    logic              refill_we;
    logic              unused_ok;

    assign a_idx    = bus.addr[OFF_W +: IDX_W];
    assign ci_idx   = bus.cache_inst_addr[OFF_W +: IDX_W];
    assign ci_tag   = bus.cache_inst_addr[31 -: TAG_W];
    assign unused_ok = ^bus.cache_inst_addr[OFF_W-1:0];

    assign acc      = bus.valid & ok_c;
    assign ci_start = (state == IDLE) & bus.cache_inst_valid;
    assign rd_en    = (acc & ~bus.uncache) | ci_start;
    assign rd_idx   = ci_start ? ci_idx : a_idx;
    assign refill_we = (state == REFILL) & bus.ret_valid;

    // Hold the cache off the fetch port while reset is asserted.
    assign bus.addr_ok = ok_c & resetn;

    // Tag compare for fetches and CACHE instructions.
    always_comb begin
        hit_vec  = '0;
        ci_vec   = '0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (vld[b_idx][w] && tag_q[w] == b_tag) begin
                hit_vec[w] = 1'b1;
                hit_line   = hit_line | data_q[w];
            end
            if (vld[c_idx][w] && tag_q[w] == ci_tag)
                ci_vec[w] = 1'b1;
        end
    end

    assign hit = |hit_vec;

    // Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        victim_n = rr[b_idx];
        found    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !vld[b_idx][w]) begin
                victim_n = WAY_W'(w);
                found    = 1'b1;
            end
        end
    end

    assign line_src  = (state == REFILL) ? bus.ret_data : hit_line;
    assign rdata_sh  = line_src >> {b_off[OFF_W-1:2], 5'b0};
    assign rnum_full = RN_W'(WPL) - RN_W'(b_off[OFF_W-1:2]);

    // Next-state and output decode.
    always_comb begin
        state_n           = state;
        ok_c              = 1'b0;
        clr_mask_n        = clr_mask;
        bus.data_ok       = 1'b0;
        bus.rdata         = '0;
        bus.rnum          = '0;
        bus.cache_inst_ok = 1'b0;
        bus.rd_req        = 1'b0;
        bus.rd_type       = 1'b0;
        bus.rd_addr       = '0;
        unique case (state)
            IDLE: begin
                ok_c = ~bus.cache_inst_valid;
                if (bus.cache_inst_valid) state_n = CLOOK;
                else if (bus.valid)
                    state_n = bus.uncache ? UREQ : LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    ok_c        = 1'b1;
                    bus.data_ok = 1'b1;
                    bus.rdata   = rdata_sh;
                    bus.rnum    = rnum_full;
                    if (!bus.valid)      state_n = IDLE;
                    else if (bus.uncache) state_n = UREQ;
                    else                 state_n = LOOKUP;
                end else begin
                    state_n = MISS;
                end
            end
            MISS: begin
                bus.rd_req  = 1'b1;
                bus.rd_type = 1'b1;
                bus.rd_addr = {b_tag, b_idx, OFF_W'(0)};
                if (bus.rd_rdy) state_n = REFILL;
            end
            REFILL: begin
                if (bus.ret_valid) begin
                    bus.data_ok = 1'b1;
                    bus.rdata   = rdata_sh;
                    bus.rnum    = rnum_full;
                    state_n     = IDLE;
                end
            end
            UREQ: begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = {b_tag, b_idx, b_off};
                if (bus.rd_rdy) state_n = URESP;
            end
            URESP: begin
                if (bus.ret_valid) begin
                    ok_c        = 1'b1;
                    bus.data_ok = 1'b1;
                    bus.rdata   = LINE_W'(bus.ret_data[31:0]);
                    bus.rnum    = RN_W'(1);
                    if (!bus.valid)      state_n = IDLE;
                    else if (bus.uncache) state_n = UREQ;
                    else                 state_n = LOOKUP;
                end
            end
            CLOOK: begin
                if (bus.cache_inst_op == 3'b000) begin
                    clr_mask_n = '1;
                    state_n    = CCLR;
                end else if (bus.cache_inst_op == 3'b100 && |ci_vec) begin
                    clr_mask_n = ci_vec;
                    state_n    = CCLR;
                end else begin
                    bus.cache_inst_ok = 1'b1;
                    state_n           = IDLE;
                end
            end
            CCLR: begin
                bus.cache_inst_ok = 1'b1;
                state_n           = IDLE;
            end
        endcase
    end

    // Control state: FSM, request buffer, valid bits, RR pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            b_tag    <= '0;
            b_idx    <= '0;
            b_off    <= '0;
            c_idx    <= '0;
            clr_mask <= '0;
            victim   <= '0;
            for (int s = 0; s < SETS; s++) begin
                vld[s] <= '0;
                rr[s]  <= '0;
            end
        end else begin
            state    <= state_n;
            clr_mask <= clr_mask_n;
            if (acc) {b_tag, b_idx, b_off} <= bus.addr;
            if (ci_start) c_idx <= ci_idx;
            if (state == LOOKUP && !hit) victim <= victim_n;
            if (refill_we) begin
                vld[b_idx][victim] <= 1'b1;
                if (WAYS > 1) rr[b_idx] <= rr[b_idx] + WAY_W'(1);
            end
            if (state == CCLR) vld[c_idx] <= vld[c_idx] & ~clr_mask;
        end
    end

    // Tag/data arrays: 1-cycle synchronous read, written on refill.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_q[w]  <= tag_ram[w][rd_idx];
                data_q[w] <= data_ram[w][rd_idx];
            end
        end
        if (refill_we) begin
            tag_ram[victim][b_idx]  <= b_tag;
            data_ram[victim][b_idx] <= bus.ret_data;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Lookup hit/miss event counters, free-running with wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else if (state == LOOKUP) begin
            if (hit) perf_hit  <= perf_hit + 32'd1;
            else     perf_miss <= perf_miss + 32'd1;
        end
    end
`endif
endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- Parametrised set-associative, blocking, read-only instruction cache; next generation of the current 2-way 128-set icache.
- Sits between the fetch stage and the AXI read bridge.
- Returns a whole-line remainder (multiple instructions) per hit, plus uncached single-word fetches and CACHE-instruction invalidation.
- Adds: configurable ways/sets/line size, invalid-way-first replacement, and a real `cache_inst_ok` handshake.

Parameters:
- WAYS, 2, associativity; power of 2, range 1..8.
- SETS, 128, sets per way; power of 2.
- LINE_BYTES, 32, line size; power of 2, range 16..64.
- Derived (localparam): OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = 32 - IDX_W - OFF_W, LINE_W = LINE_BYTES*8, WPL = LINE_BYTES/4.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- valid  in  1  fetch request
- uncache  in  1  request bypasses cache
- addr  in  32  fetch address (word aligned)
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  rdata valid this cycle
- rdata  out  LINE_W  words from addr to end of line, word 0 in [31:0], upper bits zero
- rnum  out  log2(WPL)+1  number of valid words in rdata
- cache_inst_valid  in  1  CACHE instruction request, held until ok
- cache_inst_op  in  3  3'b000 index-invalidate, 3'b100 hit-invalidate, others no-op
- cache_inst_addr  in  32  CACHE instruction address
- cache_inst_ok  out  1  one-cycle completion pulse
- rd_req  out  1  AXI read request
- rd_type  out  1  0 single word, 1 full line
- rd_addr  out  32  read address
- rd_rdy  in  1  request accepted
- ret_valid  in  1  returned data valid, single beat
- ret_data  in  LINE_W  returned line (single word in [31:0])

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state IDLE.
  - All valid bits, replacement pointers and the request buffer cleared.
  - All outputs 0, except rnum = 0.
- Tag and data arrays:
  - WAYS x SETS, synchronous read with 1-cycle latency.
  - Read enabled on acceptance of a cached request or a CACHE instruction.
  - Written only on refill.
  - Valid bits are flops.
- Request buffer latches tag/index/offset when valid && addr_ok.
- addr_ok = IDLE | (LOOKUP & hit) | (URESP & ret_valid). It is never asserted while cache_inst_valid is high in IDLE: the CACHE instruction takes priority.
- States:
  - IDLE:
    - cache_inst_valid -> CLOOK.
    - else accepted uncache -> UREQ.
    - else accepted cached -> LOOKUP.
  - LOOKUP: compare all ways.
    - Hit: data_ok = 1, rdata = hit line shifted right by offset words, rnum = WPL - offset_word. Next state LOOKUP/UREQ/IDLE according to the new request.
    - Miss: select victim, go to MISS.
  - MISS: rd_req = 1, rd_type = 1, rd_addr = {tag, index, 0}; on rd_rdy -> REFILL.
  - REFILL: on ret_valid, write the line into the victim way, set its valid bit, data_ok = 1, rdata = ret_data shifted, then -> IDLE.
  - UREQ: rd_req = 1, rd_type = 0, rd_addr = full buffered address; on rd_rdy -> URESP.
  - URESP: on ret_valid, data_ok = 1, rdata = {0, ret_data[31:0]}, rnum = 1; the next request may be accepted in the same cycle.
  - CLOOK: tags of the set at cache_inst_addr are available.
    - op 000: clear mask = all ways -> CCLR.
    - op 100: clear mask = matching valid way -> CCLR if one matches; otherwise cache_inst_ok = 1 -> IDLE.
    - other ops: cache_inst_ok = 1 -> IDLE.
  - CCLR: clear the valid bits in the mask, cache_inst_ok = 1 -> IDLE.
- Hit is a one-hot OR over ways. More than one way hitting is impossible by construction; this is not checked.
- Replacement:
  - Lowest-numbered invalid way in the set is chosen first.
  - Otherwise the per-set round-robin pointer is used; it advances by 1 modulo WAYS on each refill of that set.
  - Hits do not update the pointer.
  - WAYS = 1 -> always way 0.
- rd_req held until rd_rdy; rd_addr and rd_type stable while rd_req is high.
- Uncached fetches never allocate and never look up the arrays.
- Reset mid-refill or mid-uncache: state returns to IDLE; any later ret_valid is ignored in IDLE.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- When defined, add outputs perf_hit and perf_miss, 32 bits each:
  - perf_hit increments on every LOOKUP hit.
  - perf_miss increments on every LOOKUP miss.
  - Both wrap at 2^32 and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold fetch 0x1FC0_0004 (WAYS=2): MISS rd_addr = 0x1FC0_0000, rd_type = 1. Return a line with word i = i. Response: data_ok, rdata[31:0] = 1, rnum = 7. Refetch 0x1FC0_0004 -> hit in LOOKUP, no rd_req.
- Fill 3 distinct tags into set 5 (WAYS=2): the 3rd refill victimises way 0 (pointer), and the other tag still hits.
- Back-to-back hits at 0x100, 0x104, 0x120: addr_ok every cycle after the first; data_ok on consecutive cycles.
- Uncache fetch 0xBFC0_0010: rd_type = 0, rd_addr = 0xBFC0_0010. Response rnum = 1, rdata = ret_data[31:0]. Issuing the same address cached afterwards -> miss.
- Hit-invalidate on a resident line: cache_inst_ok after 3 cycles, next fetch misses. Index-invalidate of set 5 clears all ways. Op 3'b100 to an absent line: ok after 2 cycles, nothing cleared.
- Assert resetn low during REFILL, then pulse ret_valid: no data_ok, state IDLE, all lines invalid.
